// File: rtl/gray_ptr_rx.sv
// gray_ptr_rx: resynchronises a remote gray pointer, decodes it and reports binary pointer plus increment count (optional gray-violation check under GRAY_PTR_RX_CHECK_EN)
module gray_ptr_rx #(
  parameter int BINARY_WIDTH = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
`ifdef GRAY_PTR_RX_CHECK_EN
  input  logic                    i_err_clr,
  output logic                    o_err,
`endif
  input  logic [BINARY_WIDTH-1:0] i_gray,
  output logic [BINARY_WIDTH-1:0] o_bin,
  output logic [BINARY_WIDTH-1:0] o_delta,
  output logic                    o_valid
);
  localparam int W  = BINARY_WIDTH;
  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [1:0] RESET = 2'd0, PRIME = 2'd1, RUN = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sync_q [SYNC_STAGES];
  logic [W-1:0]  g_s, b_s, d;
  assign g_s = sync_q[SYNC_STAGES-1];
  assign d   = b_s - o_bin;
  // gray to binary: each binary bit is the XOR of all gray bits at or above it
  always_comb begin
    b_s = '0;
    for (int i = 0; i < W; i++) b_s[i] = ^(g_s >> i);
  end
  // plain flop chain on the asynchronous gray bus
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= i_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  // prime the chain silently, then report every pointer movement with its step count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= RESET;
      cnt     <= '0;
      o_bin   <= '0;
      o_delta <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (state == RESET) begin
        state <= PRIME;
        cnt   <= CW'(1);
      end else if (state == PRIME) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(SYNC_STAGES)) begin
          state   <= RUN;
          o_bin   <= b_s;
          o_delta <= '0;
        end
      end else if (d != '0) begin
        o_bin   <= b_s;
        o_delta <= d;
        o_valid <= 1'b1;
      end
    end
  end
`ifdef GRAY_PTR_RX_CHECK_EN
  logic [W-1:0] g_p, g_x;
  logic         viol;
  assign g_x  = g_s ^ g_p;
  assign viol = (g_x & (g_x - 1'b1)) != '0;
  // sticky flag when consecutive synchronised samples differ in more than one bit; a new violation beats a clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      g_p   <= '0;
      o_err <= 1'b0;
    end else begin
      g_p <= g_s;
      if (state == RUN && viol) o_err <= 1'b1;
      else if (i_err_clr) o_err <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_gray_ptr_rx.sv
// tb_gray_ptr_rx: directed and random pointer traffic checked against a cycle-level reference model of gray_ptr_rx
module tb_gray_ptr_rx;
  localparam int W = 8;
  localparam int S = 2;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic [W-1:0] ptr = '0;
  logic [W-1:0] o_bin, o_delta;
  logic         o_valid;
  logic         o_err;
  int vectors = 0, miscompares = 0, pulses = 0, p0 = 0, n = 0;
  bit armed = 0;
  logic [W-1:0] hq [$];
  logic [W-1:0] e_bin = '0, e_delta = '0;
  logic         e_valid = 1'b0, e_err = 1'b0;

  gray_ptr_rx #(.BINARY_WIDTH(W), .SYNC_STAGES(S)) dut (
    .i_clk(clk),
    .i_rst(rst),
`ifdef GRAY_PTR_RX_CHECK_EN
    .i_err_clr(clr),
    .o_err(o_err),
`endif
    .i_gray(gray_in),
    .o_bin(o_bin),
    .o_delta(o_delta),
    .o_valid(o_valid)
  );
`ifndef GRAY_PTR_RX_CHECK_EN
  assign o_err = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic set_ptr(input logic [W-1:0] v);
    ptr = v;
    gray_in = gray(v);
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  // reference model: binary pointer sampled S edges ago is what the output stage sees
  always @(posedge clk) begin
    armed = 1;
    if (rst) begin
      n = 0;
      hq.delete();
      e_bin = '0; e_delta = '0; e_valid = 1'b0; e_err = 1'b0;
    end else begin
      n++;
      hq.push_back(ptr);
      if (hq.size() > S + 2) void'(hq.pop_front());
      e_valid = 1'b0;
      if (n == S + 1) begin
        e_bin = hq[hq.size()-1-S];
        e_delta = '0;
      end else if (n > S + 1) begin
        if (hq[hq.size()-1-S] != e_bin) begin
          e_delta = hq[hq.size()-1-S] - e_bin;
          e_bin = hq[hq.size()-1-S];
          e_valid = 1'b1;
        end
`ifdef GRAY_PTR_RX_CHECK_EN
        if ($countones(gray(hq[hq.size()-1-S]) ^ gray(hq[hq.size()-2-S])) > 1) e_err = 1'b1;
        else if (clr) e_err = 1'b0;
`endif
      end
`ifdef GRAY_PTR_RX_CHECK_EN
      else if (clr && n > 1) e_err = e_err;
`endif
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      check("bin", o_bin, e_bin);
      check("delta", o_delta, e_delta);
      check("valid", o_valid, e_valid);
`ifdef GRAY_PTR_RX_CHECK_EN
      check("err", o_err, e_err);
`endif
      if (o_valid) pulses++;
    end
  end

  initial begin
    set_ptr('0);
    tick(3);
    check("rst_bin", o_bin, 0);
    check("rst_valid", o_valid, 0);
    // count 0..10, one step every 4 cycles
    rst = 1'b0;
    p0 = pulses;
    for (int v = 0; v <= 10; v++) begin
      set_ptr(W'(v));
      tick(4);
    end
    tick(S + 2);
    check("count_pulses", pulses - p0, 10);
    check("count_bin", o_bin, 8'h0A);
    check("count_delta", o_delta, 1);
    // nonzero pointer at reset release loads silently
    rst = 1'b1;
    set_ptr(8'h37);
    tick(2);
    check("mid_rst_bin", o_bin, 0);
    rst = 1'b0;
    p0 = pulses;
    tick(S + 2);
    check("prime_bin", o_bin, 8'h37);
    check("prime_pulses", pulses - p0, 0);
    check("prime_delta", o_delta, 0);
    set_ptr(8'h38);
    tick(S + 2);
    check("step_pulses", pulses - p0, 1);
    check("step_delta", o_delta, 1);
    // wrap
    set_ptr(8'hFF);
    tick(6);
    set_ptr(8'h00);
    tick(S + 1);
    check("wrap_valid", o_valid, 1);
    check("wrap_bin", o_bin, 0);
    check("wrap_delta", o_delta, 1);
    // multi-step jump
    set_ptr(8'h10);
    tick(6);
    p0 = pulses;
    set_ptr(8'h15);
    tick(S + 4);
    check("jump_pulses", pulses - p0, 1);
    check("jump_delta", o_delta, 5);
`ifdef GRAY_PTR_RX_CHECK_EN
    check("jump_err", o_err, 1);
    set_ptr(8'h16);
    tick(S - 1);
    clr = 1'b1;
    set_ptr(8'h13);
    tick(1);
    clr = 1'b0;
    tick(S + 1);
    check("clr_vs_set", o_err, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
    check("clr", o_err, 0);
`endif
    // reset while a change is in the chain
    set_ptr(8'h20);
    tick(1);
    rst = 1'b1;
    p0 = pulses;
    tick(2);
    check("inflight_bin", o_bin, 0);
    check("inflight_delta", o_delta, 0);
    rst = 1'b0;
    tick(S + 3);
    check("inflight_pulses", pulses - p0, 0);
    check("inflight_reload", o_bin, 8'h20);
    // long hold
    p0 = pulses;
    tick(100);
    check("hold_pulses", pulses - p0, 0);
    check("hold_bin", o_bin, 8'h20);
    // random steps, jumps, clears and occasional resets
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 199);
      rst = (r == 199);
      clr = ($urandom_range(0, 9) == 0);
      if (r < 80) set_ptr(ptr + 1'b1);
      else if (r < 90) set_ptr(ptr + W'($urandom_range(2, 40)));
      tick(1);
    end
    rst = 1'b0;
    clr = 1'b0;
    tick(S + 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
